// File: rtl/banked_regfile_pkg.sv
// Shared defaults and FSM encoding for the multi-bank register file.
package banked_regfile_pkg;

  localparam int DEF_WORD_BITS     = 32;
  localparam int DEF_REG_ADDR_BITS = 5;
  localparam int DEF_NUM_BANKS     = 4;
  localparam int DEF_BANK_BITS     = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_COPY  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_bank_array.sv
// Storage for all banks: one write port, three async read ports and a
// broadcast clear that zeroes one register index in every bank at once.
module regfile_bank_array
  import banked_regfile_pkg::*;
#(
  parameter int WORD_BITS     = DEF_WORD_BITS,
  parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int BANK_BITS     = DEF_BANK_BITS
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [REG_ADDR_BITS-1:0] clear_addr,
  input  logic                     wr_en,
  input  logic [BANK_BITS-1:0]     wr_bank,
  input  logic [REG_ADDR_BITS-1:0] wr_addr,
  input  logic [WORD_BITS-1:0]     wr_data,
  input  logic [BANK_BITS-1:0]     rd0_bank,
  input  logic [REG_ADDR_BITS-1:0] rd0_addr,
  output logic [WORD_BITS-1:0]     rd0_data,
  input  logic [BANK_BITS-1:0]     rd1_bank,
  input  logic [REG_ADDR_BITS-1:0] rd1_addr,
  output logic [WORD_BITS-1:0]     rd1_data,
  input  logic [BANK_BITS-1:0]     cp_bank,
  input  logic [REG_ADDR_BITS-1:0] cp_addr,
  output logic [WORD_BITS-1:0]     cp_data
);

  localparam int DEPTH = 2 ** REG_ADDR_BITS;

  // Flat storage indexed by {bank, addr}.
  logic [WORD_BITS-1:0] mem [NUM_BANKS*DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[{BANK_BITS'(b), clear_addr}] <= '0;
      end
    end else if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd0_data = mem[{rd0_bank, rd0_addr}];
  assign rd1_data = mem[{rd1_bank, rd1_addr}];
  assign cp_data  = mem[{cp_bank, cp_addr}];

endmodule

// File: rtl/banked_regfile.sv
// Multi-bank register file: scrub-on-reset, registered bank select,
// write-to-read bypass and hardware bank-to-bank copy.
module banked_regfile
  import banked_regfile_pkg::*;
#(
  parameter int WORD_BITS     = DEF_WORD_BITS,
  parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int BANK_BITS     = DEF_BANK_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_BITS-1:0] iWrAddr,
  input  logic [WORD_BITS-1:0]     iWrData,
  input  logic                     iWrValid,
  input  logic [REG_ADDR_BITS-1:0] iRd0Addr,
  input  logic [REG_ADDR_BITS-1:0] iRd1Addr,
  output logic [WORD_BITS-1:0]     oRd0Data,
  output logic [WORD_BITS-1:0]     oRd1Data,
  input  logic [BANK_BITS-1:0]     iBankSel,
  input  logic                     iBankSelValid,
  output logic [BANK_BITS-1:0]     oActiveBank,
  input  logic                     iCopyStart,
  input  logic [BANK_BITS-1:0]     iCopySrc,
  input  logic [BANK_BITS-1:0]     iCopyDst,
  output logic                     oReady,
  output logic                     oCopyDone,
  output state_t                   dbg_state
);

  localparam int DEPTH = 2 ** REG_ADDR_BITS;
  localparam logic [REG_ADDR_BITS:0] PTR_LAST = (REG_ADDR_BITS+1)'(DEPTH - 1);

  // Handshake: a request (iWrValid, iBankSelValid, iCopyStart) is taken only
  // in a cycle where oReady=1; otherwise it is dropped and must be held.
  state_t                   state;
  logic [REG_ADDR_BITS:0]   ptr;
  logic [BANK_BITS-1:0]     active_bank;
  logic [BANK_BITS-1:0]     copy_src;
  logic [BANK_BITS-1:0]     copy_dst;
  logic                     copy_done;

  logic                     ready;
  logic                     in_copy;
  logic                     wr_req;
  logic                     wr_accept;
  logic                     switch_ok;
  logic                     copy_ok;

  logic                     arr_wr_en;
  logic [BANK_BITS-1:0]     arr_wr_bank;
  logic [REG_ADDR_BITS-1:0] arr_wr_addr;
  logic [WORD_BITS-1:0]     arr_wr_data;
  logic [WORD_BITS-1:0]     arr_rd0;
  logic [WORD_BITS-1:0]     arr_rd1;
  logic [WORD_BITS-1:0]     cp_data;

  function automatic logic bank_ok(input logic [BANK_BITS-1:0] b);
    return 32'(b) < 32'(NUM_BANKS);
  endfunction

  assign ready     = (state == ST_IDLE);
  assign in_copy   = (state == ST_COPY);
  assign wr_req    = ready && iWrValid;
  assign wr_accept = wr_req && (iWrAddr != '0);
  assign switch_ok = ready && iBankSelValid && bank_ok(iBankSel);
  assign copy_ok   = ready && iCopyStart && (iCopySrc != iCopyDst) &&
                     bank_ok(iCopySrc) && bank_ok(iCopyDst);

  // The single write port is shared between writeback and the copy engine.
  assign arr_wr_en   = wr_accept || in_copy;
  assign arr_wr_bank = in_copy ? copy_dst : active_bank;
  assign arr_wr_addr = in_copy ? ptr[REG_ADDR_BITS-1:0] : iWrAddr;
  assign arr_wr_data = in_copy ? cp_data : iWrData;

  regfile_bank_array #(
    .WORD_BITS     (WORD_BITS),
    .REG_ADDR_BITS (REG_ADDR_BITS),
    .NUM_BANKS     (NUM_BANKS),
    .BANK_BITS     (BANK_BITS)
  ) u_array (
    .clk        (clk),
    .clear      (state == ST_CLEAR),
    .clear_addr (ptr[REG_ADDR_BITS-1:0]),
    .wr_en      (arr_wr_en),
    .wr_bank    (arr_wr_bank),
    .wr_addr    (arr_wr_addr),
    .wr_data    (arr_wr_data),
    .rd0_bank   (active_bank),
    .rd0_addr   (iRd0Addr),
    .rd0_data   (arr_rd0),
    .rd1_bank   (active_bank),
    .rd1_addr   (iRd1Addr),
    .rd1_data   (arr_rd1),
    .cp_bank    (copy_src),
    .cp_addr    (ptr[REG_ADDR_BITS-1:0]),
    .cp_data    (cp_data)
  );

  // Reads: r0 is hardwired zero, storage is hidden while scrubbing.
  always_comb begin
    oRd0Data = arr_rd0;
    if (state == ST_CLEAR || iRd0Addr == '0)       oRd0Data = '0;
    else if (wr_req && iWrAddr == iRd0Addr)        oRd0Data = iWrData;
  end

  always_comb begin
    oRd1Data = arr_rd1;
    if (state == ST_CLEAR || iRd1Addr == '0)       oRd1Data = '0;
    else if (wr_req && iWrAddr == iRd1Addr)        oRd1Data = iWrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      ptr         <= '0;
      active_bank <= '0;
      copy_src    <= '0;
      copy_dst    <= '0;
      copy_done   <= 1'b0;
    end else begin
      copy_done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (ptr == PTR_LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (switch_ok) active_bank <= iBankSel;
          if (copy_ok) begin
            state    <= ST_COPY;
            ptr      <= (REG_ADDR_BITS+1)'(1);
            copy_src <= iCopySrc;
            copy_dst <= iCopyDst;
          end
        end
        ST_COPY: begin
          if (ptr == PTR_LAST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            copy_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign oActiveBank = active_bank;
  assign oReady      = ready;
  assign oCopyDone   = copy_done;
  assign dbg_state   = state;

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile with a queue-based scoreboard.
module tb_banked_regfile;
  import banked_regfile_pkg::*;

  localparam int W  = DEF_WORD_BITS;
  localparam int AB = DEF_REG_ADDR_BITS;
  localparam int BB = DEF_BANK_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] iWrAddr;
  logic [W-1:0]  iWrData;
  logic          iWrValid;
  logic [AB-1:0] iRd0Addr;
  logic [AB-1:0] iRd1Addr;
  logic [W-1:0]  oRd0Data;
  logic [W-1:0]  oRd1Data;
  logic [BB-1:0] iBankSel;
  logic          iBankSelValid;
  logic [BB-1:0] oActiveBank;
  logic          iCopyStart;
  logic [BB-1:0] iCopySrc;
  logic [BB-1:0] iCopyDst;
  logic          oReady;
  logic          oCopyDone;
  state_t        dbg_state;

  always #5 clk = ~clk;

  banked_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .iWrAddr       (iWrAddr),
    .iWrData       (iWrData),
    .iWrValid      (iWrValid),
    .iRd0Addr      (iRd0Addr),
    .iRd1Addr      (iRd1Addr),
    .oRd0Data      (oRd0Data),
    .oRd1Data      (oRd1Data),
    .iBankSel      (iBankSel),
    .iBankSelValid (iBankSelValid),
    .oActiveBank   (oActiveBank),
    .iCopyStart    (iCopyStart),
    .iCopySrc      (iCopySrc),
    .iCopyDst      (iCopyDst),
    .oReady        (oReady),
    .oCopyDone     (oCopyDone),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Inputs change 1 time unit after posedge; outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %h, nothing expected", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic sel_bank(input int b);
    iBankSel      = BB'(b);
    iBankSelValid = 1'b1;
    step();
    iBankSelValid = 1'b0;
    #2;
    expect_v(W'(b));
    check("bank_sel", W'(oActiveBank));
    step();
  endtask

  task automatic rd_check(input string tag, input int a0, input logic [W-1:0] e0,
                          input int a1, input logic [W-1:0] e1);
    iRd0Addr = AB'(a0);
    iRd1Addr = AB'(a1);
    #2;
    expect_v(e0);
    check({tag, "_rd0"}, oRd0Data);
    expect_v(e1);
    check({tag, "_rd1"}, oRd1Data);
    step();
  endtask

  task automatic check_all_zero();
    for (int b = 0; b < DEF_NUM_BANKS; b++) begin
      sel_bank(b);
      for (int a = 0; a < 2 ** AB; a++) rd_check("scrub_zero", a, '0, (2 ** AB - 1) - a, '0);
    end
    sel_bank(0);
  endtask

  // Counts cycles with oReady low after reset and any stray done pulses.
  task automatic run_clear(input string tag);
    int cnt;
    int pulses;
    cnt = 0;
    pulses = 0;
    iRd0Addr = AB'(5);
    iRd1Addr = AB'(9);
    #1;
    expect_v('0);
    check({tag, "_rd_during_clear"}, oRd0Data);
    while (oReady !== 1'b1 && cnt < 100) begin
      if (oCopyDone === 1'b1) pulses++;
      cnt++;
      step();
    end
    expect_v(W'(32));
    check({tag, "_not_ready_cycles"}, W'(cnt));
    expect_v('0);
    check({tag, "_done_pulses"}, W'(pulses));
    expect_v('0);
    check({tag, "_active_bank"}, W'(oActiveBank));
    expect_v(W'(ST_IDLE));
    check({tag, "_state"}, W'(dbg_state));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int pulses;
    rst = 1'b1;
    iWrAddr = '0;
    iWrData = '0;
    iWrValid = 1'b0;
    iRd0Addr = '0;
    iRd1Addr = '0;
    iBankSel = '0;
    iBankSelValid = 1'b0;
    iCopyStart = 1'b0;
    iCopySrc = '0;
    iCopyDst = '0;

    // 1: one reset cycle, then a 32-cycle scrub of every bank
    step();
    rst = 1'b0;
    run_clear("reset");
    check_all_zero();

    // 2: same-cycle bypass, then stored value
    iWrAddr = AB'(5); iWrData = 32'hDEADBEEF; iWrValid = 1'b1;
    iRd0Addr = AB'(5); iRd1Addr = AB'(6);
    #2;
    expect_v(32'hDEADBEEF); check("bypass_rd0", oRd0Data);
    expect_v('0);           check("bypass_rd1_other", oRd1Data);
    step();
    iWrValid = 1'b0;
    #2;
    expect_v(32'hDEADBEEF); check("stored_rd0", oRd0Data);
    step();

    // 3: writes to r0 are discarded and never bypassed
    iWrAddr = '0; iWrData = 32'h1234; iWrValid = 1'b1;
    iRd0Addr = '0; iRd1Addr = '0;
    #2;
    expect_v('0); check("r0_same_rd0", oRd0Data);
    expect_v('0); check("r0_same_rd1", oRd1Data);
    step();
    iWrValid = 1'b0;
    rd_check("r0_later", 0, '0, 0, '0);

    // 4: switch and write in one cycle -> write lands in the old bank
    iWrAddr = AB'(3); iWrData = 32'hA; iWrValid = 1'b1;
    step();
    iWrValid = 1'b0;
    iBankSel = BB'(2); iBankSelValid = 1'b1;
    iWrAddr = AB'(3); iWrData = 32'hB; iWrValid = 1'b1;
    iRd0Addr = AB'(3); iRd1Addr = AB'(5);
    #2;
    expect_v(32'hB);        check("switch_bypass_rd0", oRd0Data);
    expect_v(32'hDEADBEEF); check("switch_oldbank_rd1", oRd1Data);
    expect_v('0);           check("switch_bank_not_yet", W'(oActiveBank));
    step();
    iBankSelValid = 1'b0; iWrValid = 1'b0;
    #2;
    expect_v(W'(2)); check("switch_bank_now", W'(oActiveBank));
    expect_v('0);    check("bank2_r3", oRd0Data);
    expect_v('0);    check("bank2_r5", oRd1Data);
    step();
    sel_bank(0);
    rd_check("bank0_after", 3, 32'hB, 5, 32'hDEADBEEF);

    // 5: fill bank1, copy to bank3, a write during the copy is dropped
    sel_bank(1);
    for (int i = 1; i < 2 ** AB; i++) begin
      iWrAddr = AB'(i); iWrData = W'(i); iWrValid = 1'b1;
      step();
    end
    iWrValid = 1'b0;
    rd_check("bank1_fill", 7, W'(7), 31, W'(31));
    iCopySrc = BB'(1); iCopyDst = BB'(3); iCopyStart = 1'b1;
    #2;
    expect_v(W'(1)); check("copy_start_ready", W'(oReady));
    step();
    iCopyStart = 1'b0;
    iRd0Addr = AB'(7); iRd1Addr = '0;
    lowcnt = 0; pulses = 0;
    while (oReady !== 1'b1 && lowcnt < 100) begin
      if (lowcnt < 3) begin
        iWrAddr = AB'(7); iWrData = 32'hFFFF_FFFF; iWrValid = 1'b1;
      end else begin
        iWrValid = 1'b0;
      end
      #1;
      if (lowcnt == 0) begin
        expect_v(W'(7)); check("copy_no_bypass", oRd0Data);
      end
      if (oCopyDone === 1'b1) pulses++;
      lowcnt++;
      step();
    end
    iWrValid = 1'b0;
    expect_v(W'(31)); check("copy_busy_cycles", W'(lowcnt));
    expect_v('0);     check("copy_early_pulses", W'(pulses));
    expect_v(W'(1));  check("copy_done_pulse", W'(oCopyDone));
    step();
    expect_v('0);     check("copy_done_cleared", W'(oCopyDone));
    sel_bank(3);
    for (int i = 1; i < 2 ** AB; i++) rd_check("bank3_copied", i, W'(i), 32 - i, W'(32 - i));
    sel_bank(1);
    rd_check("bank1_r7_kept", 7, W'(7), 1, W'(1));

    // 6: reset in the middle of a copy aborts it and rescrubs
    iCopySrc = BB'(3); iCopyDst = BB'(0); iCopyStart = 1'b1;
    step();
    iCopyStart = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_clear("abort");
    check_all_zero();

    // src == dst is ignored
    iCopySrc = BB'(2); iCopyDst = BB'(2); iCopyStart = 1'b1;
    step();
    iCopyStart = 1'b0;
    lowcnt = 0; pulses = 0;
    for (int i = 0; i < 35; i++) begin
      if (oReady !== 1'b1) lowcnt++;
      if (oCopyDone === 1'b1) pulses++;
      step();
    end
    expect_v('0); check("same_bank_not_ready", W'(lowcnt));
    expect_v('0); check("same_bank_pulses", W'(pulses));

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
